pipelined_rca: RTL and testbench
================================

Name: pipelined_rca

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor for the adder datapath.
- Next generation of the fixed 4-bit, 2-stage adder: configurable width and pipeline depth, valid/ready flow control, per-transaction subtract mode.
- Each stage ripples one WIDTH/STAGES-bit slice. Upper operand slices are skewed in, lower sum slices are deskewed out, so all result bits leave aligned.
- Sits between operand-issue logic and any consumer that can apply backpressure.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of register stages and adder slices; 1 <= STAGES <= WIDTH; slice width SW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in, used when sub=0.
- sub  input  1  1 = compute a - b.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of MSB; for sub this is the not-borrow flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation): all stage valid bits, out_valid, sum, cout and all skew/deskew/carry registers clear to 0 immediately. In-flight transactions are discarded, with no partial output. First acceptance is possible on the first clk edge after rst_n rises.
- Advance enable: en = out_ready | ~out_valid. in_ready = en (combinational, no dependence on in_valid).
- Accept: a transaction enters on an edge where in_valid & in_ready.
- Stall (en=0): every pipeline register holds. sum, cout and out_valid stay stable until out_ready.
- Bubbles are not collapsed internally. On an edge with en=1 and in_valid=0, a valid=0 bubble enters stage 0.
- Operand conditioning at entry: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1) adds slice bits [k*SW +: SW] of a and b_eff with the carry from stage k-1 (stage 0 uses c0). It registers the slice sum and carry-out.
- Slice k operands are delayed k cycles before use.
- Slice k sum is delayed STAGES-1-k further cycles.
- Latency is exactly STAGES enabled cycles from acceptance to out_valid=1 with all WIDTH sum bits and cout of that same transaction.
- Throughput is one result per cycle when out_ready stays 1.
- Arithmetic: {cout,sum} = a + b_eff + c0 modulo 2^(WIDTH+1). There are no wrap exceptions; a full-scale wrap (0xFFFF+1) yields sum 0, cout 1.
- Ordering: results emerge strictly in acceptance order.
- Simultaneous events: out_ready=1 and in_valid=1 while full → output retires and a new input is accepted on the same edge.
- out_valid=1 with out_ready=0 → no acceptance.
- sub and cin are sampled only at acceptance. Changes during a stall have no effect on accepted transactions.
- STAGES=1 degenerates to one registered full-width ripple adder with latency 1.

Optional Feature:
- Macro: PRCA_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = signed two's-complement overflow of the result: carry into MSB XOR carry out of MSB.
  - Pipelined alongside sum. Reset 0. Held during stall. Valid with out_valid.
- Undefined:
  - Port ovf absent.
  - No extra registers.
  - All other behaviour identical.

Test Plan (WIDTH=16, STAGES=4):
- Reset, then a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 → out_valid exactly 4 cycles after acceptance; sum=0x0000, cout=1.
- 8 back-to-back transactions (a=i*0x1111, b=0x0F0F, cin=i&1) with out_ready=1 → 8 consecutive out_valid cycles, in order; each sum = a+b+cin mod 2^16.
- sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0. sub=1, a=0x0007, b=0x0005 → sum=0x0002, cout=1 (cin ignored in both).
- Fill pipeline, drop out_ready for 5 cycles → in_ready=0 throughout, sum/cout/out_valid stable; on release, remaining results drain in order with no loss or duplication.
- Assert rst_n=0 asynchronously with 3 transactions in flight → out_valid, sum, cout go 0 without a clk edge. After release, none of the old results appear, and a new a=0x1234, b=0x1111 yields 0x2345 after 4 cycles.
- With PRCA_OVF_EN defined: a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0. a=0x8000, sub=1, b=0x0001 → sum=0x7FFF, ovf=1.

Source files
------------

// File: rtl/pipelined_rca.sv
// pipelined_rca
//   Pipelined ripple-carry adder/subtractor with valid/ready flow control.
//   Stage k adds operand slice k (SW = WIDTH/STAGES bits) together with the carry
//   from stage k-1. Operands not yet consumed travel down the pipe, which skews
//   the upper slices in. Finished sum slices shift toward the LSB end of the sum
//   register, which deskews them, so all WIDTH bits leave on the same cycle.
//
//   Optional macro PRCA_OVF_EN adds the port ovf, the signed overflow flag. It is
//   registered alongside sum.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present
//   in_ready   block accepts operands (= out_ready | ~out_valid)
//   a, b       operands, WIDTH bits
//   cin        carry-in, used when sub=0
//   sub        1 = compute a - b
//   out_valid  result present
//   out_ready  consumer accepts result
//   sum        result, WIDTH bits
//   cout       carry out of MSB (not-borrow when sub=1)
//   ovf        signed overflow (PRCA_OVF_EN only)
module pipelined_rca #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PRCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SW = WIDTH / STAGES;

  logic             w_en;

  // Stage registers. r_a/r_b hold the operand bits that later stages still need,
  // shifted down so the next slice is always in bits [SW-1:0]. r_s collects the
  // finished slices from the top down.
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_v [STAGES];

  logic [WIDTH-1:0] w_a_in  [STAGES];
  logic [WIDTH-1:0] w_b_in  [STAGES];
  logic [WIDTH-1:0] w_s_in  [STAGES];
  logic             w_c_in  [STAGES];
  logic             w_v_in  [STAGES];
  logic [SW-1:0]    w_slice [STAGES];
  logic             w_c_nxt [STAGES];

  assign w_en     = out_ready | ~r_v[STAGES-1];
  assign in_ready = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_entry
      // Subtraction is a + ~b + 1. cin and sub are captured only at this point.
      assign w_a_in[k] = a;
      assign w_b_in[k] = sub ? ~b : b;
      assign w_c_in[k] = sub | cin;
      assign w_s_in[k] = '0;
      assign w_v_in[k] = in_valid;
    end else begin : g_chain
      assign w_a_in[k] = r_a[k-1];
      assign w_b_in[k] = r_b[k-1];
      assign w_c_in[k] = r_c[k-1];
      assign w_s_in[k] = r_s[k-1];
      assign w_v_in[k] = r_v[k-1];
    end
    assign {w_c_nxt[k], w_slice[k]} = {1'b0, w_a_in[k][SW-1:0]}
                                    + {1'b0, w_b_in[k][SW-1:0]}
                                    + (SW+1)'(w_c_in[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_s[i] <= '0;
        r_c[i] <= 1'b0;
        r_v[i] <= 1'b0;
      end
    end else if (w_en) begin
      for (int i = 0; i < STAGES; i++) begin
        r_v[i] <= w_v_in[i];
        r_a[i] <= w_a_in[i] >> SW;
        r_b[i] <= w_b_in[i] >> SW;
        // The new slice enters at the top. After the final stage, slice 0 has
        // arrived at bits [SW-1:0].
        r_s[i] <= (w_s_in[i] >> SW) | (WIDTH'(w_slice[i]) << (WIDTH - SW));
        r_c[i] <= w_c_nxt[i];
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];

`ifdef PRCA_OVF_EN
  // The carry into the MSB is recovered from the sum bit: s = a ^ b ^ c_in_msb.
  logic w_ovf_nxt;
  logic r_ovf;

  assign w_ovf_nxt = w_a_in[STAGES-1][SW-1] ^ w_b_in[STAGES-1][SW-1]
                   ^ w_slice[STAGES-1][SW-1] ^ w_c_nxt[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
module tb_pipelined_rca;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PRCA_OVF_EN
  logic         ovf;
`endif

  pipelined_rca #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef PRCA_OVF_EN
    .cout      (cout),
    .ovf       (ovf)
`else
    .cout      (cout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           n;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_pops = 0;
  int   en_cnt = 0;
  int   n_exp_pops;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic ovf_of(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                  input logic ts, input logic [W-1:0] es);
    logic [W-1:0] be;
    be = ts ? ~tb_ : tb_;
    return (ta[W-1] == be[W-1]) && (es[W-1] != ta[W-1]);
  endfunction

  // Drive a transaction and hold it until it is accepted. The expected result
  // is queued together with the enabled-edge count at acceptance.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                      input logic ts, input logic [W-1:0] es, input logic ec);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    #1;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (in_ready) ok = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (ok) begin
      e.s = es; e.c = ec; e.o = ovf_of(ta, tb_, ts, es); e.n = en_cnt;
      q.push_back(e);
    end else begin
      check("send_accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    check("drain_queue_empty", q.size(), 0);
  endtask

  // Monitor: compares each retired result with the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        n_pops++;
        if (q.size() == 0) begin
          check("unexpected_result", {15'd0, cout, sum}, 32'hDEAD);
        end else begin
          e = q.pop_front();
          check("sum", sum, e.s);
          check("cout", cout, e.c);
          check("latency", en_cnt - e.n, S);
`ifdef PRCA_OVF_EN
          check("ovf", ovf, e.o);
`endif
        end
      end
      if (in_ready) en_cnt++;
    end
  end

  initial begin
    logic [16:0] r;
    bit          seen;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full-scale wrap.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    idle();
    drain();

    // Back-to-back stream.
    for (int i = 0; i < 8; i++) begin
      r = 17'(i * 16'h1111) + 17'h0F0F + 17'(i & 1);
      send(16'(i * 16'h1111), 16'h0F0F, 1'(i & 1), 1'b0, r[15:0], r[16]);
    end
    idle();
    drain();

    // Subtraction. cin is ignored.
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    send(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
    idle();
    drain();

    // Fill with the consumer stalled, then hold the stall for 5 cycles.
    out_ready = 1'b0;
    send(16'h1000, 16'h0234, 1'b0, 1'b0, 16'h1234, 1'b0);
    send(16'h0010, 16'h0020, 1'b1, 1'b1, 16'hFFF0, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'(i & 1); cin = ~sub;
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_sum", sum, 16'h1234);
      check("stall_cout", cout, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(16'h0100, 16'h0001, 1'b0, 1'b0, 16'h0101, 1'b0);
    idle();
    drain();

    // Asynchronous reset with transactions in flight.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0);
    send(16'h4000, 16'h0001, 1'b1, 1'b0, 16'h4002, 1'b0);
    send(16'h0F00, 16'h00F0, 1'b0, 1'b0, 16'h0FF0, 1'b0);
    idle();
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      #1;
      seen = out_valid;
    end
    check("pre_reset_out_valid", out_valid, 1);
    check("pre_reset_sum", sum, 16'h3333);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_cout", cout, 0);
    q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);
    idle();
    drain();
    n_exp_pops = 17;

`ifdef PRCA_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);
    idle();
    drain();
    n_exp_pops = 19;
`endif

    repeat (6) @(negedge clk);
    check("retired_count", n_pops, n_exp_pops);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
